m_axi_ctrl: RTL
===============

# m_axi_ctrl

Single-outstanding AXI initiator that turns one-shot register commands from local control logic into AXI write (AW/W/B) and read (AR/R) transactions. It is the initiator-side counterpart of the team's AXI register slave and sits between sequencer/CPU-side logic and the AXI interconnect. Each transaction is a single beat of 32 bits with a fixed ID. A watchdog aborts transactions whose slave never responds.

## Interface
- TXN_ID, 4'h0, value driven on awid_o/wid_o/arid_o and expected on bid_i/rid_i
- TIMEOUT, 256, cycles allowed from command accept to B/R handshake; 0 disables the watchdog
- clk  in  1  clock
- areset  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write / cmd_addr / cmd_wdata / cmd_wstrb  in  1/32/32/4  1=write 0=read; address; write data; byte strobes (ignored for reads)
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_write / rsp_rdata / rsp_resp / rsp_timeout  out  1/32/2/1  echo of cmd_write; read data (0 for writes); AXI resp code; watchdog fired
- awid_o / awaddr_o / awvalid_o / awready_i  out/out/out/in  4/32/1/1  write address channel
- wid_o / wdata_o / wstrb_o / wlast_o / wvalid_o / wready_i  out×5/in  4/32/4/1/1/1  write data channel; wlast_o=1 whenever wvalid_o=1
- bid_i / bresp_i / bvalid_i / bready_o  in/in/in/out  4/2/1/1  write response channel
- arid_o / araddr_o / arvalid_o / arready_i  out/out/out/in  4/32/1/1  read address channel
- rid_i / rdata_i / rresp_i / rlast_i / rvalid_i / rready_o  in×5/out  4/32/2/1/1/1  read data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1; on cmd_valid, register addr/data/strb/write and go to WR_REQ or RD_REQ.
- WR_REQ: awvalid_o and wvalid_o are raised together. Each is dropped independently after its own handshake, tracked by aw_done/w_done flags. When both handshakes are done, go to WR_RESP.
- WR_RESP: bready_o=1. On bvalid_i, capture bresp_i and go to RSP.
- RD_REQ: arvalid_o=1 until arready_i, then go to RD_RESP.
- RD_RESP: rready_o=1. On rvalid_i, capture rdata_i/rresp_i and go to RSP.
- Response checks: bid_i/rid_i ≠ TXN_ID, or rlast_i=0 on the R beat, forces rsp_resp=2'b10 (SLVERR). rdata is still captured.
- RSP: rsp_valid=1 until rsp_ready, then go to IDLE. cmd_ready=0 in every state except IDLE.
- Watchdog: a counter clears on command accept and increments in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - When count reaches TIMEOUT: drop all AXI valid/ready outputs, set rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, and go to RSP.
  - A handshake in that same cycle wins over the timeout.
- AXI payload outputs hold stable while their valid is high.
- awaddr_o and araddr_o both drive the latched address.

## Timing
- All outputs are registered.
- Reset values: every valid/ready/rsp output 0, except cmd_ready=1. Payloads are 0; wlast_o=0; rsp_resp=2'b00.
- Command accepted on edge N: AW/W/AR valid at N+1.
- With a zero-wait slave: AW/W handshake at N+1, bready_o=1 at N+2, bvalid_i at N+2, rsp_valid at N+3. Reads have the same latency.
- Valid is never withdrawn before its handshake, except on watchdog abort.
- bvalid_i/rvalid_i arriving before the READY phase (before WR_RESP/RD_RESP) is not sampled until that phase.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronously), and the state returns to IDLE. No response is issued for the lost command.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Structure
- Shared package axi_pkg holds:
  - resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11)
  - state enum for this block
  - AXI_ID_W=4, AXI_ADDR_W=32, AXI_DATA_W=32, AXI_STRB_W=4
- One sub-module, axi_watchdog: counter with clear/enable inputs and an expired output, parameterized by TIMEOUT.

## Test plan
- Write cmd addr=3, wdata=0xDEADBEEF, strb=4'hF to a zero-wait slave → awaddr_o=3 and wvalid_o at N+1; rsp_valid at N+3 with rsp_resp=00, rsp_timeout=0.
- Read cmd addr=3 after the previous write → arvalid_o at N+1; rsp_rdata=0xDEADBEEF, rsp_write=0.
- Write strb=4'b0101 with awready_i held low for 5 cycles and wready_i=1 → wvalid_o drops after 1 cycle; awvalid_o/awaddr_o stay stable until handshake; exactly one B accepted.
- TIMEOUT=16, slave never asserts bvalid_i → at cycle 16 after accept, bready_o=0, rsp_timeout=1, rsp_resp=10.
- Read with rid_i=4'h5 (≠TXN_ID) and rresp_i=00 → rsp_resp=10, rdata still captured. rsp_ready held low 3 cycles → rsp_valid held and cmd_ready=0 throughout.
- areset asserted while in RD_RESP → arvalid_o/rready_o/rsp_valid=0 immediately and cmd_ready=1 after release; the next command completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI widths, response codes and initiator FSM states
package axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_t;

endpackage

// File: rtl/m_axi_ctrl_if.sv
// rtl/m_axi_ctrl_if.sv - single-beat AXI bus between the initiator and its slave
interface m_axi_ctrl_if;
  import axi_pkg::*;

  logic [AXI_ID_W-1:0]   awid_o;
  logic [AXI_ADDR_W-1:0] awaddr_o;
  logic                  awvalid_o;
  logic                  awready_i;

  logic [AXI_ID_W-1:0]   wid_o;
  logic [AXI_DATA_W-1:0] wdata_o;
  logic [AXI_STRB_W-1:0] wstrb_o;
  logic                  wlast_o;
  logic                  wvalid_o;
  logic                  wready_i;

  logic [AXI_ID_W-1:0]   bid_i;
  logic [1:0]            bresp_i;
  logic                  bvalid_i;
  logic                  bready_o;

  logic [AXI_ID_W-1:0]   arid_o;
  logic [AXI_ADDR_W-1:0] araddr_o;
  logic                  arvalid_o;
  logic                  arready_i;

  logic [AXI_ID_W-1:0]   rid_i;
  logic [AXI_DATA_W-1:0] rdata_i;
  logic [1:0]            rresp_i;
  logic                  rlast_i;
  logic                  rvalid_i;
  logic                  rready_o;

  modport master (
    output awid_o, awaddr_o, awvalid_o, input awready_i,
    output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, input wready_i,
    input bid_i, bresp_i, bvalid_i, output bready_o,
    output arid_o, araddr_o, arvalid_o, input arready_i,
    input rid_i, rdata_i, rresp_i, rlast_i, rvalid_i, output rready_o
  );

  modport slave (
    input awid_o, awaddr_o, awvalid_o, output awready_i,
    input wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, output wready_i,
    output bid_i, bresp_i, bvalid_i, input bready_o,
    input arid_o, araddr_o, arvalid_o, output arready_i,
    output rid_i, rdata_i, rresp_i, rlast_i, rvalid_i, input rready_o
  );

endinterface

// File: rtl/axi_watchdog.sv
// rtl/axi_watchdog.sv - saturating transaction watchdog; TIMEOUT=0 disables it
module axi_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic areset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIMIT_M1 = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires one cycle early so the abort lands on the edge where the count reaches TIMEOUT.
  assign o_expired = (TIMEOUT != 0) && i_enable && (r_count >= LIMIT_M1);

endmodule

// File: rtl/m_axi_ctrl.sv
// rtl/m_axi_ctrl.sv - single-outstanding AXI initiator turning register commands into one-beat AXI transfers
module m_axi_ctrl
  import axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] TXN_ID  = '0,
  parameter int                  TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AXI_ADDR_W-1:0] cmd_addr,
  input  logic [AXI_DATA_W-1:0] cmd_wdata,
  input  logic [AXI_STRB_W-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [AXI_DATA_W-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  m_axi_ctrl_if.master          axi
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_aw_done;
  logic       r_w_done;
  logic       w_aw_done_nxt;
  logic       w_w_done_nxt;
  logic       w_accept;
  logic       w_b_fire;
  logic       w_r_fire;
  logic       w_abort;
  logic       w_busy;
  logic       w_expired;
  logic [1:0] w_b_resp;
  logic [1:0] w_r_resp;

  assign w_busy = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                  (r_state == RD_REQ) || (r_state == RD_RESP);

  // A wrong ID or a missing RLAST overrides whatever the slave reported.
  assign w_b_resp = (axi.bid_i != TXN_ID) ? SLVERR : axi.bresp_i;
  assign w_r_resp = ((axi.rid_i != TXN_ID) || !axi.rlast_i) ? SLVERR : axi.rresp_i;

  axi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .areset    (areset),
    .i_clear   (w_accept),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_accept      = 1'b0;
    w_b_fire      = 1'b0;
    w_r_fire      = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept      = 1'b1;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        w_aw_done_nxt = r_aw_done | (axi.awvalid_o & axi.awready_i);
        w_w_done_nxt  = r_w_done | (axi.wvalid_o & axi.wready_i);
        if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = WR_RESP;
        else if (w_expired)                w_abort = 1'b1;
      end
      WR_RESP: begin
        if (axi.bvalid_i) begin
          w_b_fire    = 1'b1;
          w_state_nxt = RSP;
        end else if (w_expired) begin
          w_abort = 1'b1;
        end
      end
      RD_REQ: begin
        if (axi.arvalid_o && axi.arready_i) w_state_nxt = RD_RESP;
        else if (w_expired)                 w_abort = 1'b1;
      end
      RD_RESP: begin
        if (axi.rvalid_i) begin
          w_r_fire    = 1'b1;
          w_state_nxt = RSP;
        end else if (w_expired) begin
          w_abort = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = RSP;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state       <= IDLE;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= OKAY;
      rsp_timeout   <= 1'b0;
      axi.awid_o    <= '0;
      axi.awaddr_o  <= '0;
      axi.awvalid_o <= 1'b0;
      axi.wid_o     <= '0;
      axi.wdata_o   <= '0;
      axi.wstrb_o   <= '0;
      axi.wlast_o   <= 1'b0;
      axi.wvalid_o  <= 1'b0;
      axi.bready_o  <= 1'b0;
      axi.arid_o    <= '0;
      axi.araddr_o  <= '0;
      axi.arvalid_o <= 1'b0;
      axi.rready_o  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_aw_done     <= w_aw_done_nxt;
      r_w_done      <= w_w_done_nxt;
      // Handshake outputs are registered copies of the upcoming state.
      cmd_ready     <= (w_state_nxt == IDLE);
      rsp_valid     <= (w_state_nxt == RSP);
      axi.awvalid_o <= (w_state_nxt == WR_REQ) && !w_aw_done_nxt;
      axi.wvalid_o  <= (w_state_nxt == WR_REQ) && !w_w_done_nxt;
      axi.wlast_o   <= (w_state_nxt == WR_REQ) && !w_w_done_nxt;
      axi.bready_o  <= (w_state_nxt == WR_RESP);
      axi.arvalid_o <= (w_state_nxt == RD_REQ);
      axi.rready_o  <= (w_state_nxt == RD_RESP);

      if (w_accept) begin
        axi.awid_o   <= TXN_ID;
        axi.wid_o    <= TXN_ID;
        axi.arid_o   <= TXN_ID;
        axi.awaddr_o <= cmd_addr;
        axi.araddr_o <= cmd_addr;
        axi.wdata_o  <= cmd_wdata;
        axi.wstrb_o  <= cmd_wstrb;
        rsp_write    <= cmd_write;
        rsp_rdata    <= '0;
        rsp_resp     <= OKAY;
        rsp_timeout  <= 1'b0;
      end
      if (w_b_fire) begin
        rsp_resp <= w_b_resp;
      end
      if (w_r_fire) begin
        rsp_rdata <= axi.rdata_i;
        rsp_resp  <= w_r_resp;
      end
      if (w_abort) begin
        rsp_rdata   <= '0;
        rsp_resp    <= SLVERR;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
